// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - shared defaults and types for the register-read/decode stage
//   Defines the default widths, the per-source operand selector enum
//   (fwd_sel_e) and the ex_bundle_t flag bundle held in the ID/EX register.
//   Optional feature macro used by importers: ID_FWD_EN.
package id_stage_pkg;

   localparam int unsigned ID_DATA_W = 64;
   localparam int unsigned ID_NREGS  = 32;
   localparam int unsigned ID_CTRL_W = 8;

   typedef enum logic [2:0] {
      FWD_ZERO,
      FWD_EX,
      FWD_MEM,
      FWD_WB,
      FWD_RF
   } fwd_sel_e;

   // Width-independent part of the ID/EX register; the parameterised data
   // fields (operands, rw, ctrl) live beside it in the stage itself.
   typedef struct packed {
      logic valid;
      logic reg_write;
      logic mem_read;
   } ex_bundle_t;

endpackage

// File: rtl/id_hazard_unit.sv
// rtl/id_hazard_unit.sv - operand source selection and load-use / RAW stall detection
//   Macro: ID_FWD_EN (defined: EX/MEM forwarding, stall only on load-use;
//          undefined: no EX/MEM forwarding, stall on any EX/MEM producer match).
//   Ports:
//     id_valid, id_ra, id_rb, id_use_imm         instruction in ID
//     ex_valid, ex_reg_write, ex_mem_read, ex_rw  ID/EX register contents
//     mem_reg_write, mem_rw, wb_reg_write, wb_rw  downstream producers
//     sel_a, sel_b                                operand source per source port
//     hazard                                      raw stall request (before flush/reset gating)
module id_hazard_unit import id_stage_pkg::*; #(
   parameter int unsigned AW       = 5,
   parameter int unsigned ZERO_REG = 31
) (
   input  logic          id_valid,
   input  logic [AW-1:0] id_ra,
   input  logic [AW-1:0] id_rb,
   input  logic          id_use_imm,
   input  logic          ex_valid,
   input  logic          ex_reg_write,
   input  logic          ex_mem_read,
   input  logic [AW-1:0] ex_rw,
   input  logic          mem_reg_write,
   input  logic [AW-1:0] mem_rw,
   input  logic          wb_reg_write,
   input  logic [AW-1:0] wb_rw,
   output fwd_sel_e      sel_a,
   output fwd_sel_e      sel_b,
   output logic          hazard
);

   localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

   logic [AW-1:0] src [2];
   fwd_sel_e      sel [2];
   logic [1:0]    used;
   logic [1:0]    is_zero;
   logic [1:0]    hit_ex;
   logic [1:0]    hit_mem;
   logic [1:0]    hit_wb;
   logic [1:0]    hit_stall;

   assign src[0] = id_ra;
   assign src[1] = id_rb;
   // B is not read from the register file when the immediate replaces it.
   assign used   = {~id_use_imm, 1'b1};

`ifdef ID_FWD_EN
   logic ex_fwd_ok;
   // A load's data is not available in EX, so it is never forwarded from there.
   assign ex_fwd_ok = ex_valid & ex_reg_write & ~ex_mem_read;
`endif

   always_comb begin
      is_zero   = '0;
      hit_ex    = '0;
      hit_mem   = '0;
      hit_wb    = '0;
      hit_stall = '0;
      for (int i = 0; i < 2; i++) begin
         sel[i]     = FWD_RF;
         is_zero[i] = (src[i] == ZERO_IDX);
         hit_wb[i]  = wb_reg_write & (src[i] == wb_rw);
`ifdef ID_FWD_EN
         hit_ex[i]    = ex_fwd_ok & (src[i] == ex_rw);
         hit_mem[i]   = mem_reg_write & (src[i] == mem_rw);
         hit_stall[i] = id_valid & used[i] & ex_valid & ex_mem_read &
                        (ex_rw != ZERO_IDX) & (src[i] == ex_rw);
`else
         // Without forwarding every in-flight producer ahead of WB must drain first.
         hit_stall[i] = id_valid & used[i] & ~is_zero[i] &
                        ((ex_valid & (ex_reg_write | ex_mem_read) & (src[i] == ex_rw)) |
                         (mem_reg_write & (src[i] == mem_rw)));
`endif
         if (is_zero[i]) begin
            sel[i] = FWD_ZERO;
         end else if (hit_ex[i]) begin
            sel[i] = FWD_EX;
         end else if (hit_mem[i]) begin
            sel[i] = FWD_MEM;
         end else if (hit_wb[i]) begin
            sel[i] = FWD_WB;
         end
      end
   end

   assign sel_a  = sel[0];
   assign sel_b  = sel[1];
   assign hazard = |hit_stall;

endmodule

// File: rtl/id_stage_hazard.sv
// rtl/id_stage_hazard.sv - register-read/decode stage with forwarding, stall, flush and ID/EX register
//   Macro: ID_FWD_EN (see id_hazard_unit).
//   Ports:
//     clk, reset_n                                clock, asynchronous active-low reset
//     id_valid, id_ra, id_rb, id_rw               instruction fields from IF/ID
//     id_reg_write, id_mem_read, id_use_imm       instruction attributes
//     id_imm, id_ctrl                             immediate and pass-through control
//     flush                                       kill the instruction in ID
//     ex_result, mem_result, mem_rw, mem_reg_write, wb_rw, wb_reg_write, wb_data
//                                                 downstream results / write-back
//     stall                                       hold PC and IF/ID (combinational)
//     ex_valid, ex_reg_write, ex_mem_read, ex_a, ex_b, ex_rw, ex_ctrl
//                                                 registered ID/EX outputs
module id_stage_hazard import id_stage_pkg::*; #(
   parameter int unsigned DATA_W   = ID_DATA_W,
   parameter int unsigned NREGS    = ID_NREGS,
   parameter int unsigned AW       = $clog2(NREGS),
   parameter int unsigned ZERO_REG = NREGS - 1,
   parameter int unsigned CTRL_W   = ID_CTRL_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              id_valid,
   input  logic [AW-1:0]     id_ra,
   input  logic [AW-1:0]     id_rb,
   input  logic [AW-1:0]     id_rw,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_use_imm,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              flush,
   input  logic [DATA_W-1:0] ex_result,
   input  logic [DATA_W-1:0] mem_result,
   input  logic [AW-1:0]     mem_rw,
   input  logic              mem_reg_write,
   input  logic [AW-1:0]     wb_rw,
   input  logic              wb_reg_write,
   input  logic [DATA_W-1:0] wb_data,
   output logic              stall,
   output logic              ex_valid,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [AW-1:0]     ex_rw,
   output logic [CTRL_W-1:0] ex_ctrl
);

   localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

   logic [DATA_W-1:0] rf_q [NREGS];

   ex_bundle_t        flags_q, flags_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [AW-1:0]     rw_q, rw_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;

   fwd_sel_e          sel_a, sel_b;
   logic              hazard;
   logic              load_en;
   logic [DATA_W-1:0] op_a, op_b_reg, op_b;

   // Register file: not reset; the zero register is never written.
   always_ff @(posedge clk) begin
      if (wb_reg_write && (wb_rw != ZERO_IDX)) begin
         rf_q[wb_rw] <= wb_data;
      end
   end

   id_hazard_unit #(
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
   ) u_hazard (
      .id_valid      (id_valid),
      .id_ra         (id_ra),
      .id_rb         (id_rb),
      .id_use_imm    (id_use_imm),
      .ex_valid      (flags_q.valid),
      .ex_reg_write  (flags_q.reg_write),
      .ex_mem_read   (flags_q.mem_read),
      .ex_rw         (rw_q),
      .mem_reg_write (mem_reg_write),
      .mem_rw        (mem_rw),
      .wb_reg_write  (wb_reg_write),
      .wb_rw         (wb_rw),
      .sel_a         (sel_a),
      .sel_b         (sel_b),
      .hazard        (hazard)
   );

   always_comb begin
      op_a = rf_q[id_ra];
      case (sel_a)
         FWD_ZERO: op_a = '0;
         FWD_EX:   op_a = ex_result;
         FWD_MEM:  op_a = mem_result;
         FWD_WB:   op_a = wb_data;
         default:  op_a = rf_q[id_ra];
      endcase
      op_b_reg = rf_q[id_rb];
      case (sel_b)
         FWD_ZERO: op_b_reg = '0;
         FWD_EX:   op_b_reg = ex_result;
         FWD_MEM:  op_b_reg = mem_result;
         FWD_WB:   op_b_reg = wb_data;
         default:  op_b_reg = rf_q[id_rb];
      endcase
   end

   assign op_b    = id_use_imm ? id_imm : op_b_reg;

   // Flush overrides the stall request; reset forces stall low immediately.
   assign stall   = hazard & ~flush & reset_n;
   assign load_en = id_valid & ~flush & ~hazard;

   // Bubbles keep the previous data fields so the outputs stay deterministic.
   always_comb begin
      flags_d = '0;
      a_d     = a_q;
      b_d     = b_q;
      rw_d    = rw_q;
      ctrl_d  = ctrl_q;
      if (load_en) begin
         flags_d.valid     = 1'b1;
         flags_d.reg_write = id_reg_write;
         flags_d.mem_read  = id_mem_read;
         a_d               = op_a;
         b_d               = op_b;
         rw_d              = id_rw;
         ctrl_d            = id_ctrl;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rw_q    <= '0;
         ctrl_q  <= '0;
      end else begin
         flags_q <= flags_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rw_q    <= rw_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign ex_valid     = flags_q.valid;
   assign ex_reg_write = flags_q.reg_write;
   assign ex_mem_read  = flags_q.mem_read;
   assign ex_a         = a_q;
   assign ex_b         = b_q;
   assign ex_rw        = rw_q;
   assign ex_ctrl      = ctrl_q;

endmodule

// File: tb/tb_id_stage_hazard.sv
// tb/tb_id_stage_hazard.sv - directed self-checking bench for id_stage_hazard
module tb_id_stage_hazard;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        id_valid;
   logic [4:0]  id_ra, id_rb, id_rw;
   logic        id_reg_write, id_mem_read, id_use_imm;
   logic [63:0] id_imm;
   logic [7:0]  id_ctrl;
   logic        flush;
   logic [63:0] ex_result, mem_result;
   logic [4:0]  mem_rw, wb_rw;
   logic        mem_reg_write, wb_reg_write;
   logic [63:0] wb_data;
   logic        stall;
   logic        ex_valid, ex_reg_write, ex_mem_read;
   logic [63:0] ex_a, ex_b;
   logic [4:0]  ex_rw;
   logic [7:0]  ex_ctrl;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_stage_hazard dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .id_valid      (id_valid),
      .id_ra         (id_ra),
      .id_rb         (id_rb),
      .id_rw         (id_rw),
      .id_reg_write  (id_reg_write),
      .id_mem_read   (id_mem_read),
      .id_use_imm    (id_use_imm),
      .id_imm        (id_imm),
      .id_ctrl       (id_ctrl),
      .flush         (flush),
      .ex_result     (ex_result),
      .mem_result    (mem_result),
      .mem_rw        (mem_rw),
      .mem_reg_write (mem_reg_write),
      .wb_rw         (wb_rw),
      .wb_reg_write  (wb_reg_write),
      .wb_data       (wb_data),
      .stall         (stall),
      .ex_valid      (ex_valid),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_read   (ex_mem_read),
      .ex_a          (ex_a),
      .ex_b          (ex_b),
      .ex_rw         (ex_rw),
      .ex_ctrl       (ex_ctrl)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid      = 1'b0;
      id_reg_write  = 1'b0;
      id_mem_read   = 1'b0;
      id_use_imm    = 1'b0;
      flush         = 1'b0;
      mem_reg_write = 1'b0;
      wb_reg_write  = 1'b0;
   endtask

   task automatic drain();
      idle();
      step();
   endtask

   task automatic issue(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                        input logic rwen, input logic mrd, input logic uimm,
                        input logic [63:0] imm, input logic [7:0] ctrl);
      id_valid     = 1'b1;
      id_ra        = ra;
      id_rb        = rb;
      id_rw        = rw;
      id_reg_write = rwen;
      id_mem_read  = mrd;
      id_use_imm   = uimm;
      id_imm       = imm;
      id_ctrl      = ctrl;
   endtask

   task automatic wb_write(input logic [4:0] rw, input logic [63:0] d);
      idle();
      wb_reg_write = 1'b1;
      wb_rw        = rw;
      wb_data      = d;
      step();
      wb_reg_write = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset_n    = 1'b0;
      idle();
      id_ra      = '0; id_rb = '0; id_rw = '0;
      id_imm     = '0; id_ctrl = '0;
      ex_result  = '0; mem_result = '0;
      mem_rw     = '0; wb_rw = '0; wb_data = '0;

      // A would-be producer match during reset must not raise stall.
      id_valid = 1'b1; id_ra = 5'd3; mem_reg_write = 1'b1; mem_rw = 5'd3;
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", stall, 0);
      check("rst_valid", ex_valid, 0);
      check("rst_a", ex_a, 0);
      check("rst_rw", ex_rw, 0);
      check("rst_ctrl", ex_ctrl, 0);
      check("rst_rwen", ex_reg_write, 0);
      check("rst_mrd", ex_mem_read, 0);
      idle();
      reset_n = 1'b1;

      for (int i = 0; i <= 10; i++) wb_write(5'(i), 64'(100 + i));
      wb_write(5'd5, 64'd50);

      // Read X5 after write-back.
      issue(5'd5, 5'd6, 5'd2, 1'b1, 1'b0, 1'b0, 64'd0, 8'hA5);
      #1 check("rd_stall", stall, 0);
      step();
      check("rd_valid", ex_valid, 1);
      check("rd_a", ex_a, 50);
      check("rd_b", ex_b, 106);
      check("rd_rw", ex_rw, 2);
      check("rd_ctrl", ex_ctrl, 8'hA5);
      check("rd_rwen", ex_reg_write, 1);
      check("rd_mrd", ex_mem_read, 0);

      // Asynchronous reset mid-stream.
      idle();
      reset_n = 1'b0;
      #1;
      check("arst_valid", ex_valid, 0);
      check("arst_a", ex_a, 0);
      check("arst_b", ex_b, 0);
      check("arst_rw", ex_rw, 0);
      check("arst_ctrl", ex_ctrl, 0);
      check("arst_rwen", ex_reg_write, 0);
      reset_n = 1'b1;
      issue(5'd5, 5'd1, 5'd9, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00);
      step();
      check("rf_kept_a", ex_a, 50);
      check("rf_kept_b", ex_b, 101);

      // Same-cycle WB bypass, then the written value from the register file.
      drain();
      issue(5'd7, 5'd1, 5'd9, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00);
      wb_reg_write = 1'b1; wb_rw = 5'd7; wb_data = 64'd777;
      #1 check("wbbyp_stall", stall, 0);
      step();
      check("wbbyp_a", ex_a, 777);
      wb_reg_write = 1'b0;
      step();
      check("wbrf_a", ex_a, 777);

      // Immediate B operand; a producer match on rb is ignored.
      drain();
      issue(5'd1, 5'd9, 5'd9, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 8'h00);
      mem_reg_write = 1'b1; mem_rw = 5'd9;
      #1 check("imm_stall", stall, 0);
      step();
      check("imm_b", ex_b, 64'hFFFF_FFFF_FFFF_FFFB);
      check("imm_a", ex_a, 101);
      mem_reg_write = 1'b0;

      // Zero register: writes ignored, reads 0, never a hazard.
      wb_write(5'd31, 64'd99);
      issue(5'd31, 5'd31, 5'd9, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00);
      step();
      check("zr_a", ex_a, 0);
      check("zr_b", ex_b, 0);
      issue(5'd1, 5'd2, 5'd31, 1'b1, 1'b1, 1'b0, 64'd0, 8'h00);
      step();
      issue(5'd31, 5'd31, 5'd9, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00);
      #1 check("zr_ld_stall", stall, 0);
      step();
      check("zr_ld_valid", ex_valid, 1);
      check("zr_ld_a", ex_a, 0);

      // Flush in the same cycle as a load-use hazard.
      drain();
      issue(5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 64'd0, 8'h00);
      step();
      issue(5'd4, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);
      flush = 1'b1;
      #1 check("fl_stall", stall, 0);
      step();
      check("fl_valid", ex_valid, 0);
      check("fl_rwen", ex_reg_write, 0);
      check("fl_mrd", ex_mem_read, 0);
      check("fl_hold_a", ex_a, 101);
      flush = 1'b0;

      // Load-use on source A.
      drain();
      issue(5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 64'd0, 8'h00);
      step();
      issue(5'd4, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, 64'd0, 8'h3C);
      #1 check("lu_stall", stall, 1);
      step();
      check("lu_bubble", ex_valid, 0);
      check("lu_bub_mrd", ex_mem_read, 0);
      check("lu_bub_rwen", ex_reg_write, 0);
      mem_reg_write = 1'b1; mem_rw = 5'd4; mem_result = 64'd444;
`ifdef ID_FWD_EN
      #1 check("lu_stall_end", stall, 0);
      step();
`else
      #1 check("lu_mem_stall", stall, 1);
      step();
      check("lu_mem_bubble", ex_valid, 0);
      mem_reg_write = 1'b0;
      wb_reg_write = 1'b1; wb_rw = 5'd4; wb_data = 64'd444;
      #1 check("lu_wb_stall", stall, 0);
      step();
      wb_reg_write = 1'b0;
`endif
      check("lu_valid", ex_valid, 1);
      check("lu_a", ex_a, 444);
      check("lu_b", ex_b, 102);
      check("lu_ctrl", ex_ctrl, 8'h3C);
      mem_reg_write = 1'b0;

      // Load-use on source B.
      drain();
      issue(5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 64'd0, 8'h00);
      step();
      issue(5'd1, 5'd6, 5'd8, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00);
      #1 check("lub_stall", stall, 1);
      drain();

`ifdef ID_FWD_EN
      // EX forward, MEM forward, and priority among EX, MEM and WB.
      drain();
      issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);
      step();
      issue(5'd3, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00);
      ex_result = 64'd16;
      #1 check("fex_stall", stall, 0);
      step();
      check("fex_a", ex_a, 16);
      issue(5'd3, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00);
      mem_reg_write = 1'b1; mem_rw = 5'd3; mem_result = 64'd32;
      step();
      check("fmem_a", ex_a, 32);
      issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);
      mem_reg_write = 1'b0;
      step();
      issue(5'd3, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00);
      mem_reg_write = 1'b1; mem_rw = 5'd3; mem_result = 64'd32;
      wb_reg_write = 1'b1; wb_rw = 5'd3; wb_data = 64'd48;
      step();
      check("fexmem_a", ex_a, 16);
      check("fexmem_b", ex_b, 16);
      issue(5'd3, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00);
      step();
      check("fmemwb_a", ex_a, 32);
      idle();
`else
      // Back-to-back RAW on X7 without forwarding.
      drain();
      issue(5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);
      step();
      issue(5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 64'd0, 8'h77);
      ex_result = 64'd16;
      #1 check("raw_ex_stall", stall, 1);
      step();
      check("raw_ex_bubble", ex_valid, 0);
      mem_reg_write = 1'b1; mem_rw = 5'd7; mem_result = 64'd32;
      #1 check("raw_mem_stall", stall, 1);
      step();
      check("raw_mem_bubble", ex_valid, 0);
      mem_reg_write = 1'b0;
      wb_reg_write = 1'b1; wb_rw = 5'd7; wb_data = 64'd70;
      #1 check("raw_wb_stall", stall, 0);
      step();
      check("raw_valid", ex_valid, 1);
      check("raw_a", ex_a, 70);
      check("raw_b", ex_b, 101);
      check("raw_ctrl", ex_ctrl, 8'h77);
      idle();
`endif

      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
